// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU between
// requester A (execute) and requester B (branch/address unit).
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ_A,
    input  logic [XLEN-1:0] A_X1,
    input  logic [XLEN-1:0] A_X2,
    input  logic [2:0]      A_OP,
    input  logic            A_SUB,
    input  logic            ACK_A,
    input  logic            REQ_B,
    input  logic [XLEN-1:0] B_X1,
    input  logic [XLEN-1:0] B_X2,
    input  logic [2:0]      B_OP,
    input  logic            B_SUB,
    input  logic            ACK_B,
    output logic            GNT_A,
    output logic            GNT_B,
    output logic            DONE_A,
    output logic            DONE_B,
    output logic [XLEN-1:0] RES_OUT,
    output logic            ZERO,
    output logic            BUSY,
    output logic [XLEN-1:0] ALU_X1,
    output logic [XLEN-1:0] ALU_X2,
    output logic [2:0]      ALU_OP,
    output logic            ALU_J,
    output logic            ALU_B,
    input  logic [XLEN-1:0] ALU_RES
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    // Winner of the most recent grant; it is also the current owner,
    // since ownership only changes on a grant.
    logic last_b;
    logic pick_a;
    logic pick_b;
    logic owner_ack;

    // Next-state decode and round-robin grant selection
    always_comb begin
        state_nx  = state;
        pick_a    = 1'b0;
        pick_b    = 1'b0;
        owner_ack = last_b ? ACK_B : ACK_A;
        case (state)
            ST_IDLE: begin
                pick_a = REQ_A && (!REQ_B || last_b);
                pick_b = REQ_B && !pick_a;
                if (pick_a || pick_b) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT:  state_nx = ST_DONE;
            ST_DONE: begin
                if (owner_ack) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign GNT_A = pick_a;
    assign GNT_B = pick_b;
    assign BUSY  = (state != ST_IDLE);
    assign ALU_B = 1'b0;

    // State register and arbitration history
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            last_b <= 1'b1;
        end else begin
            state <= state_nx;
            if (pick_a || pick_b) begin
                last_b <= pick_b;
            end
        end
    end

    // ALU operand drive registers, loaded only in the grant cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            ALU_X1 <= '0;
            ALU_X2 <= '0;
            ALU_OP <= '0;
            ALU_J  <= 1'b0;
        end else if (pick_a) begin
            ALU_X1 <= A_X1;
            ALU_X2 <= A_X2;
            ALU_OP <= A_OP;
            ALU_J  <= A_SUB;
        end else if (pick_b) begin
            ALU_X1 <= B_X1;
            ALU_X2 <= B_X2;
            ALU_OP <= B_OP;
            ALU_J  <= B_SUB;
        end
    end

    // Result capture after the ALU latency; hold until the owner acks
    always_ff @(posedge CLK) begin
        if (RST) begin
            RES_OUT <= '0;
            ZERO    <= 1'b0;
            DONE_A  <= 1'b0;
            DONE_B  <= 1'b0;
        end else if (state == ST_WAIT) begin
            RES_OUT <= ALU_RES;
            ZERO    <= (ALU_RES == '0);
            DONE_A  <= !last_b;
            DONE_B  <= last_b;
        end else if (state == ST_DONE && owner_ack) begin
            DONE_A <= 1'b0;
            DONE_B <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter
// against a registered ALU stand-in and a transaction-level model.
module tb_alu_arbiter;

    localparam int XLEN = 32;

    logic            CLK = 1'b0;
    logic            RST;
    logic            REQ_A, REQ_B, ACK_A, ACK_B;
    logic [XLEN-1:0] A_X1, A_X2, B_X1, B_X2;
    logic [2:0]      A_OP, B_OP;
    logic            A_SUB, B_SUB;
    logic            GNT_A, GNT_B, DONE_A, DONE_B;
    logic [XLEN-1:0] RES_OUT;
    logic            ZERO, BUSY;
    logic [XLEN-1:0] ALU_X1, ALU_X2;
    logic [2:0]      ALU_OP;
    logic            ALU_J, ALU_B;
    logic [XLEN-1:0] alu_res;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_A(REQ_A), .A_X1(A_X1), .A_X2(A_X2),
        .A_OP(A_OP), .A_SUB(A_SUB), .ACK_A(ACK_A),
        .REQ_B(REQ_B), .B_X1(B_X1), .B_X2(B_X2),
        .B_OP(B_OP), .B_SUB(B_SUB), .ACK_B(ACK_B),
        .GNT_A(GNT_A), .GNT_B(GNT_B),
        .DONE_A(DONE_A), .DONE_B(DONE_B),
        .RES_OUT(RES_OUT), .ZERO(ZERO), .BUSY(BUSY),
        .ALU_X1(ALU_X1), .ALU_X2(ALU_X2),
        .ALU_OP(ALU_OP), .ALU_J(ALU_J), .ALU_B(ALU_B),
        .ALU_RES(alu_res)
    );

    function automatic logic [31:0] alu_f(
        input logic [31:0] x1,
        input logic [31:0] x2,
        input logic [2:0]  op,
        input logic        j
    );
        logic [31:0] r;
        case (op)
            3'b000: r = j ? x1 - x2 : x1 + x2;
            3'b001: r = x1 << x2[4:0];
            3'b010: r = {31'd0, $signed(x1) < $signed(x2)};
            3'b011: r = {31'd0, x1 < x2};
            3'b100: r = x1 ^ x2;
            3'b101: begin
                if (j) r = $signed(x1) >>> x2[4:0];
                else   r = x1 >> x2[4:0];
            end
            3'b110: r = x1 | x2;
            default: r = x1 & x2;
        endcase
        return r;
    endfunction

    // Registered ALU: one cycle latency, result register not reset
    always @(posedge CLK) begin
        alu_res <= alu_f(ALU_X1, ALU_X2, ALU_OP, ALU_J);
    end

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic idle_inputs;
        REQ_A = 0; REQ_B = 0; ACK_A = 0; ACK_B = 0;
        A_X1 = 0; A_X2 = 0; A_OP = 0; A_SUB = 0;
        B_X1 = 0; B_X2 = 0; B_OP = 0; B_SUB = 0;
    endtask

    task automatic do_reset;
        tick;
        RST = 1;
        idle_inputs;
        tick;
        RST = 0;
    endtask

    task automatic test_reset;
        logic [106:0] v;
        RST = 1;
        idle_inputs;
        tick;
        tick;
        #1;
        v = {GNT_A, GNT_B, DONE_A, DONE_B, RES_OUT, ZERO, BUSY,
             ALU_X1, ALU_X2, ALU_OP, ALU_J, ALU_B};
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", v);
        end
        tick;
        RST = 0;
    endtask

    task automatic test_single_add;
        do_reset;
        tick;
        REQ_A = 1; A_X1 = 5; A_X2 = 7; A_OP = 3'b000; A_SUB = 0;
        #1;
        n_checks++;
        if ({GNT_A, GNT_B} !== 2'b10) begin
            n_fail++;
            $display("FAIL add_grant: got %b, want 10", {GNT_A, GNT_B});
        end
        for (int c = 1; c <= 3; c++) begin
            tick;
            REQ_A = 0;
            #1;
            if (c == 1) begin
                n_checks++;
                if (ALU_X1 !== 5 || ALU_X2 !== 7 || ALU_OP !== 0) begin
                    n_fail++;
                    $display("FAIL add_alu_drive: got %h %h %b, want 5 7 000",
                             ALU_X1, ALU_X2, ALU_OP);
                end
            end
            n_checks++;
            if (DONE_A !== (c == 3)) begin
                n_fail++;
                $display("FAIL add_done_c%0d: got %b, want %b",
                         c, DONE_A, (c == 3));
            end
        end
        n_checks++;
        if (RES_OUT !== 12 || ZERO !== 0) begin
            n_fail++;
            $display("FAIL add_result: got %0d z=%b, want 12 z=0", RES_OUT, ZERO);
        end
        ACK_A = 1;
        tick;
        ACK_A = 0;
        #1;
        n_checks++;
        if (DONE_A !== 0 || BUSY !== 0) begin
            n_fail++;
            $display("FAIL add_ack: got done=%b busy=%b, want 0 0", DONE_A, BUSY);
        end
    endtask

    task automatic test_tie;
        int g_side[$];
        int g_time[$];
        do_reset;
        tick;
        REQ_A = 1; A_X1 = 10; A_X2 = 3; A_OP = 0; A_SUB = 1;
        REQ_B = 1; B_X1 = 4;  B_X2 = 4; B_OP = 4; B_SUB = 0;
        for (int t = 0; t < 40 && g_side.size() < 3; t++) begin
            #1;
            if (GNT_A) begin g_side.push_back(0); g_time.push_back(t); end
            if (GNT_B) begin g_side.push_back(1); g_time.push_back(t); end
            ACK_A = DONE_A;
            ACK_B = DONE_B;
            tick;
        end
        REQ_A = 0; REQ_B = 0; ACK_A = 0; ACK_B = 0;
        n_checks++;
        if (g_side.size() != 3) begin
            n_fail++;
            $display("FAIL tie_count: got %0d grants, want 3", g_side.size());
        end else begin
            n_checks++;
            if (g_side[0] != 0 || g_side[1] != 1 || g_side[2] != 0) begin
                n_fail++;
                $display("FAIL tie_order: got %0d %0d %0d, want 0 1 0",
                         g_side[0], g_side[1], g_side[2]);
            end
            n_checks++;
            if (g_time[1] - g_time[0] != 4 || g_time[2] - g_time[1] != 4) begin
                n_fail++;
                $display("FAIL tie_spacing: got %0d %0d, want 4 4",
                         g_time[1] - g_time[0], g_time[2] - g_time[1]);
            end
        end
    endtask

    task automatic test_sub_zero;
        int lat;
        do_reset;
        tick;
        REQ_B = 1; B_X1 = 32'h1234; B_X2 = 32'h1234; B_OP = 0; B_SUB = 1;
        #1;
        n_checks++;
        if ({GNT_A, GNT_B} !== 2'b01) begin
            n_fail++;
            $display("FAIL subz_grant: got %b, want 01", {GNT_A, GNT_B});
        end
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            tick;
            REQ_B = 0;
            #1;
            if (DONE_B) begin lat = c; break; end
        end
        n_checks++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL subz_latency: got %0d, want 3", lat);
        end
        n_checks++;
        if (RES_OUT !== 0 || ZERO !== 1 || DONE_A !== 0) begin
            n_fail++;
            $display("FAIL subz_result: got %h z=%b da=%b, want 0 z=1 da=0",
                     RES_OUT, ZERO, DONE_A);
        end
        ACK_B = 1;
        tick;
        ACK_B = 0;
    endtask

    task automatic test_hold;
        int lat;
        logic [31:0] exp_a, exp_b;
        do_reset;
        tick;
        REQ_A = 1; A_X1 = $urandom; A_X2 = $urandom;
        A_OP = 3'($urandom_range(0, 7)); A_SUB = 1'($urandom);
        exp_a = alu_f(A_X1, A_X2, A_OP, A_SUB);
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            tick;
            REQ_A = 0;
            #1;
            if (DONE_A) begin lat = c; break; end
        end
        n_checks++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL hold_latency: got %0d, want 3", lat);
        end
        REQ_B = 1; B_X1 = $urandom; B_X2 = $urandom;
        B_OP = 3'($urandom_range(0, 7)); B_SUB = 1'($urandom);
        exp_b = alu_f(B_X1, B_X2, B_OP, B_SUB);
        ACK_B = 1;
        for (int c = 0; c < 10; c++) begin
            tick;
            #1;
            n_checks++;
            if (RES_OUT !== exp_a || DONE_A !== 1 || GNT_B !== 0) begin
                n_fail++;
                $display("FAIL hold_c%0d: got %h da=%b gb=%b, want %h 1 0",
                         c, RES_OUT, DONE_A, GNT_B, exp_a);
            end
        end
        ACK_B = 0;
        ACK_A = 1;
        #1;
        n_checks++;
        if (GNT_B !== 0) begin
            n_fail++;
            $display("FAIL hold_ack_cycle: got gb=%b, want 0", GNT_B);
        end
        tick;
        ACK_A = 0;
        #1;
        n_checks++;
        if (GNT_B !== 1 || DONE_A !== 0) begin
            n_fail++;
            $display("FAIL hold_regrant: got gb=%b da=%b, want 1 0", GNT_B, DONE_A);
        end
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            tick;
            REQ_B = 0;
            #1;
            if (DONE_B) begin lat = c; break; end
        end
        n_checks++;
        if (lat != 3 || RES_OUT !== exp_b) begin
            n_fail++;
            $display("FAIL hold_b_result: got lat=%0d %h, want 3 %h",
                     lat, RES_OUT, exp_b);
        end
        ACK_B = 1;
        tick;
        ACK_B = 0;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [106:0] v;
        logic [31:0] exp_b;
        do_reset;
        tick;
        REQ_A = 1; A_X1 = 32'h55; A_X2 = 32'h22; A_OP = 0; A_SUB = 0;
        tick;
        REQ_A = 0;
        tick;
        RST = 1;
        tick;
        #1;
        v = {GNT_A, GNT_B, DONE_A, DONE_B, RES_OUT, ZERO, BUSY,
             ALU_X1, ALU_X2, ALU_OP, ALU_J, ALU_B};
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h, want 0", v);
        end
        RST = 0;
        for (int c = 0; c < 5; c++) begin
            tick;
            #1;
            n_checks++;
            if ({DONE_A, DONE_B, GNT_A, GNT_B, BUSY} !== 5'b0) begin
                n_fail++;
                $display("FAIL rstmid_quiet_c%0d: got %b, want 00000",
                         c, {DONE_A, DONE_B, GNT_A, GNT_B, BUSY});
            end
        end
        tick;
        REQ_B = 1; B_X1 = $urandom; B_X2 = $urandom; B_OP = 3'b110; B_SUB = 0;
        exp_b = alu_f(B_X1, B_X2, B_OP, B_SUB);
        #1;
        n_checks++;
        if (GNT_B !== 1) begin
            n_fail++;
            $display("FAIL rstmid_regrant: got %b, want 1", GNT_B);
        end
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            tick;
            REQ_B = 0;
            #1;
            if (DONE_B) begin lat = c; break; end
        end
        n_checks++;
        if (lat != 3 || RES_OUT !== exp_b) begin
            n_fail++;
            $display("FAIL rstmid_result: got lat=%0d %h, want 3 %h",
                     lat, RES_OUT, exp_b);
        end
        ACK_B = 1;
        tick;
        ACK_B = 0;
    endtask

    task automatic test_slt;
        int lat;
        logic [31:0] exp_r;
        do_reset;
        for (int k = 0; k < 2; k++) begin
            tick;
            REQ_A = 1; A_X1 = 32'hFFFF_FFFF; A_X2 = 1; A_SUB = 0;
            A_OP = (k == 0) ? 3'b010 : 3'b011;
            exp_r = (k == 0) ? 32'd1 : 32'd0;
            lat = -1;
            for (int c = 1; c <= 8; c++) begin
                tick;
                REQ_A = 0;
                #1;
                if (DONE_A) begin lat = c; break; end
            end
            n_checks++;
            if (lat != 3 || RES_OUT !== exp_r) begin
                n_fail++;
                $display("FAIL slt_op%b: got lat=%0d %h, want 3 %h",
                         A_OP, lat, RES_OUT, exp_r);
            end
            ACK_A = 1;
            tick;
            ACK_A = 0;
        end
    endtask

    task automatic test_random;
        logic        req[2];
        logic        ack[2];
        logic [31:0] rx1[2], rx2[2];
        logic [2:0]  rop[2];
        logic        rsub[2];
        logic        gprev[2];
        logic        busy_m, done_m, owner_m, last_m;
        logic        exp_ga, exp_gb;
        logic [31:0] pend;
        int          cnt;
        do_reset;
        busy_m = 0; done_m = 0; owner_m = 0; last_m = 1; cnt = 0; pend = 0;
        for (int s = 0; s < 2; s++) begin
            req[s] = 0; ack[s] = 0; gprev[s] = 0;
            rx1[s] = 0; rx2[s] = 0; rop[s] = 0; rsub[s] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            tick;
            for (int s = 0; s < 2; s++) begin
                if (req[s] && gprev[s]) begin
                    req[s] = ($urandom_range(0, 3) == 0);
                end else if (req[s]) begin
                    if ($urandom_range(0, 15) == 0) req[s] = 0;
                end else begin
                    req[s] = ($urandom_range(0, 2) == 0);
                end
                if (!req[s] || gprev[s]) begin
                    rx1[s]  = $urandom;
                    rx2[s]  = ($urandom_range(0, 3) == 0) ? rx1[s] : $urandom;
                    rop[s]  = 3'($urandom_range(0, 7));
                    rsub[s] = 1'($urandom);
                end
                if (done_m && owner_m == 1'(s))
                    ack[s] = ($urandom_range(0, 2) == 0);
                else
                    ack[s] = ($urandom_range(0, 7) == 0);
            end
            REQ_A = req[0]; A_X1 = rx1[0]; A_X2 = rx2[0];
            A_OP = rop[0]; A_SUB = rsub[0]; ACK_A = ack[0];
            REQ_B = req[1]; B_X1 = rx1[1]; B_X2 = rx2[1];
            B_OP = rop[1]; B_SUB = rsub[1]; ACK_B = ack[1];
            #1;
            exp_ga = !busy_m && req[0] && (!req[1] || last_m);
            exp_gb = !busy_m && req[1] && !exp_ga;
            n_checks++;
            if ({GNT_A, GNT_B, DONE_A, DONE_B, BUSY} !==
                {exp_ga, exp_gb, done_m && !owner_m, done_m && owner_m, busy_m}) begin
                n_fail++;
                $display("FAIL rand_ctrl n=%0d: got %b, want %b", n,
                         {GNT_A, GNT_B, DONE_A, DONE_B, BUSY},
                         {exp_ga, exp_gb, done_m && !owner_m, done_m && owner_m, busy_m});
            end
            if (done_m) begin
                n_checks++;
                if (RES_OUT !== pend || ZERO !== (pend == 0)) begin
                    n_fail++;
                    $display("FAIL rand_result n=%0d: got %h z=%b, want %h z=%b",
                             n, RES_OUT, ZERO, pend, (pend == 0));
                end
            end
            gprev[0] = exp_ga;
            gprev[1] = exp_gb;
            if (exp_ga || exp_gb) begin
                owner_m = exp_gb;
                last_m  = exp_gb;
                busy_m  = 1;
                cnt     = 1;
                pend    = exp_gb ? alu_f(rx1[1], rx2[1], rop[1], rsub[1])
                                 : alu_f(rx1[0], rx2[0], rop[0], rsub[0]);
            end else if (busy_m && !done_m) begin
                cnt++;
                if (cnt == 3) done_m = 1;
            end else if (done_m && ack[owner_m]) begin
                done_m = 0;
                busy_m = 0;
            end
        end
        tick;
        idle_inputs;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs;
        RST = 1;
        test_reset;
        test_single_add;
        test_tie;
        test_sub_zero;
        test_hold;
        test_reset_mid;
        test_slt;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
